fetch: RTL and testbench
========================

# fetch

Instruction fetch stage: owns the program counter, issues reads to instruction memory, and delivers the registered pc/instr/prediction triple that the decode stage consumes. Contains a direct-mapped BTB with 2-bit counters and a one-entry hold buffer that keeps a response that returns during a pipeline stall. Sits between instruction memory and decode. Executes redirects on branch mispredicts signalled by execute.

## Interface
- RESET_VECTOR, 64'h0, PC loaded at reset.
- BTB_ENTRIES, 16, BTB depth; power of 2, ≥2.
- clk  in  1  clock; all state changes on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- stall_in  in  1  hazard stall; same signal decode receives.
- redirect_in  in  1  execute resolved a mispredict this cycle.
- redirect_pc_in  in  64  correct next PC.
- bp_update_in  in  1  resolved-branch training strobe.
- bp_pc_in  in  64  PC of the resolved branch.
- bp_taken_in  in  1  resolved direction.
- bp_target_in  in  64  resolved taken target.
- imem_addr_out  out  64  read address (= PC register).
- imem_read_out  out  1  read request.
- imem_ready_in  in  1  data valid this cycle; meaningful only while imem_read_out=1.
- imem_data_in  in  64  instruction word.
- flush_out  out  1  to decode flush_in; combinational, = redirect_in.
- valid_out  out  1  instr_out holds a real instruction.
- pc_out  out  64  PC of instr_out.
- instr_out  out  64  instruction, or NOP (64'h0) when invalid.
- branch_predicted_taken_out  out  1  BTB prediction made for instr_out.

## Operation
- Reset (async): pc=RESET_VECTOR, hold buffer empty, all BTB valid bits 0, pc_out=0, instr_out=NOP, valid_out=0, branch_predicted_taken_out=0.
- imem_read_out = reset_n & !hold_full & !redirect_in.
- Memory has retry semantics. The address may change, or the read may drop, at any cycle without ready. A response completes only on a cycle with read=1 and ready=1.
- Next PC: BTB hit with counter[1]=1 gives the BTB target. Otherwise it is pc+8. Addition wraps modulo 2^64.
- Response accepted, !stall_in: output registers take {1, pc, data, pred}, pc advances to the next PC.
- Response accepted, stall_in: the triple goes to the hold buffer (hold_full=1) and pc advances. The output registers hold.
- !stall_in, hold_full: output registers load from the hold buffer and hold_full clears. A read is not issued that cycle, because read was gated by hold_full.
- !stall_in, no response, hold empty: output becomes a bubble with valid_out=0 and instr_out=NOP. pc_out and the prediction bit also clear.
- Stall with no response: everything holds.
- redirect_in has highest priority and overrides stall:
  - pc becomes redirect_pc_in.
  - hold_full clears.
  - The output becomes a bubble.
  - Any same-cycle response is discarded; read is low, so it cannot complete.
- BTB addressing:
  - index = pc[3+IW-1:3], with IW = log2(BTB_ENTRIES).
  - tag = pc[63:3+IW].
  - Each entry holds {valid, tag, target, ctr[1:0]}.
- BTB update on bp_update_in, using the entry indexed by bp_pc_in:
  - taken, hit: ctr saturating +1, target rewritten.
  - taken, miss: entry allocated with tag, target, ctr=2'b10, valid=1.
  - not taken, hit: ctr saturating −1.
  - not taken, miss: no change.
- Lookup and update on the same index in the same cycle: the lookup sees the pre-update contents (read-before-write).

## Timing
- Fetch latency: imem_addr_out=A in cycle N with ready in N gives pc_out=A and valid_out=1 in N+1.
- Sustained throughput: one instruction per cycle while ready stays high and there is no stall.
- Redirect in cycle N:
  - flush_out=1 in N.
  - imem_addr_out=redirect_pc_in in N+1.
  - If ready in N+1, the first correct instruction is at the output in N+2.
- BTB update in N affects predictions from N+1.
- Release from a stall with the hold buffer full: the held instruction appears the cycle after stall_in falls, then fetch resumes at the advanced PC.
- Deasserting reset_n mid-operation restores all reset values immediately. In-flight responses are lost.

## Structure
- Shared header, alongside the other cpu headers:
  - NOP constant (64'h0).
  - INSTR_BYTES (8).
  - BTB counter encodings: strongly/weakly taken/not-taken.
- One sub-module: `btb`.
  - Combinational lookup port (pc → hit, taken, target).
  - Synchronous update port.
  - Async-reset valid bits.
- Fetch contains the PC register, hold buffer, request gating and output registers.

## Test plan
- Reset then ready held high, RESET_VECTOR=64'h1000 → pc_out 0x1000, 0x1008, 0x1010 on consecutive cycles, valid_out=1; all outputs 0/NOP during reset.
- Ready at 0x1000 while stall_in=1 → hold_full, read drops, outputs unchanged. Stall released → pc_out=0x1000 the next cycle, then fetch resumes at 0x1008.
- redirect_in with redirect_pc_in=0x2000, simultaneous with a response and with stall_in=1 → flush_out=1, response discarded, hold cleared, next output bubble, imem_addr_out=0x2000 the next cycle.
- bp_update taken twice for pc 0x1010 → target 0x3000 → the next fetch of 0x1010 gives branch_predicted_taken_out=1 and a next address of 0x3000. Two not-taken updates → falls back to 0x1018.
- Same-cycle update and lookup of the same index on a new entry → that lookup predicts not-taken, and the following lookup predicts taken.
- Ready withheld for 3 cycles → valid_out=0 and instr_out=NOP for those cycles, address stable; reset_n pulsed mid-stream → immediate return to reset values and RESET_VECTOR refetch.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: NOP word, instruction size, BTB counter states
// and the pc/instr/prediction slot carried by the hold buffer and output registers.
package fetch_pkg;

  localparam logic [63:0] NOP         = 64'h0;
  localparam logic [63:0] INSTR_BYTES = 64'd8;

  typedef enum logic [1:0] {
    CTR_STRONG_NT = 2'b00,
    CTR_WEAK_NT   = 2'b01,
    CTR_WEAK_T    = 2'b10,
    CTR_STRONG_T  = 2'b11
  } ctr_e;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [63:0] instr;
    logic        pred;
  } fetch_slot_t;

  function automatic ctr_e ctr_inc(ctr_e c);
    logic [1:0] v;
    v = c;
    return (c == CTR_STRONG_T) ? c : ctr_e'(v + 2'b01);
  endfunction

  function automatic ctr_e ctr_dec(ctr_e c);
    logic [1:0] v;
    v = c;
    return (c == CTR_STRONG_NT) ? c : ctr_e'(v - 2'b01);
  endfunction

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped BTB: combinational lookup, one-cycle synchronous update; lookups
// during an update of the same index see the old entry. No backpressure.
module btb
  import fetch_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] lookup_pc,
  output logic        hit,
  output logic        taken,
  output logic [63:0] target,
  input  logic        update,
  input  logic [63:0] update_pc,
  input  logic        update_taken,
  input  logic [63:0] update_target
);

  localparam int IW = $clog2(ENTRIES);
  localparam int TW = 64 - 3 - IW;

  logic [ENTRIES-1:0] valid_q;
  logic [TW-1:0]      tag_q    [ENTRIES];
  logic [63:0]        target_q [ENTRIES];
  ctr_e               ctr_q    [ENTRIES];

  logic [IW-1:0] lk_idx;
  logic [IW-1:0] up_idx;
  logic          up_hit;
  logic          unused_low_bits;

  assign lk_idx = lookup_pc[3+IW-1:3];
  assign up_idx = update_pc[3+IW-1:3];

  assign hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lookup_pc[63:3+IW]);
  assign taken  = hit && ctr_q[lk_idx][1];
  assign target = target_q[lk_idx];

  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == update_pc[63:3+IW]);

  assign unused_low_bits = ^{lookup_pc[2:0], update_pc[2:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (update && update_taken && !up_hit) begin
      valid_q[up_idx] <= 1'b1;
    end
  end

  // Payload needs no reset: it is only observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (update) begin
      if (update_taken) begin
        tag_q[up_idx]    <= update_pc[63:3+IW];
        target_q[up_idx] <= update_target;
        ctr_q[up_idx]    <= up_hit ? ctr_inc(ctr_q[up_idx]) : CTR_WEAK_T;
      end else if (up_hit) begin
        ctr_q[up_idx]    <= ctr_dec(ctr_q[up_idx]);
      end
    end
  end

endmodule

// File: rtl/fetch.sv
// Fetch stage: PC, BTB prediction, retrying imem reads, one-entry hold buffer, registered
// output (1-cycle latency). Stall parks one response in the hold buffer; redirect overrides all.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_VECTOR = 64'h0,
  parameter int          BTB_ENTRIES  = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_in,
  input  logic        redirect_in,
  input  logic [63:0] redirect_pc_in,
  input  logic        bp_update_in,
  input  logic [63:0] bp_pc_in,
  input  logic        bp_taken_in,
  input  logic [63:0] bp_target_in,
  output logic [63:0] imem_addr_out,
  output logic        imem_read_out,
  input  logic        imem_ready_in,
  input  logic [63:0] imem_data_in,
  output logic        flush_out,
  output logic        valid_out,
  output logic [63:0] pc_out,
  output logic [63:0] instr_out,
  output logic        branch_predicted_taken_out
);

  localparam fetch_slot_t BUBBLE = '{valid: 1'b0, pc: 64'h0, instr: NOP, pred: 1'b0};

  logic [63:0] pc_q;
  logic        hold_full_q;
  fetch_slot_t hold_q;
  fetch_slot_t out_q;

  logic        pred_hit;
  logic        pred_taken;
  logic [63:0] pred_target;
  logic        accept;
  logic [63:0] next_pc;
  fetch_slot_t resp;

  btb #(.ENTRIES(BTB_ENTRIES)) u_btb (
    .clk           (clk),
    .reset_n       (reset_n),
    .lookup_pc     (pc_q),
    .hit           (pred_hit),
    .taken         (pred_taken),
    .target        (pred_target),
    .update        (bp_update_in),
    .update_pc     (bp_pc_in),
    .update_taken  (bp_taken_in),
    .update_target (bp_target_in)
  );

  // A full hold buffer blocks new reads so a second response can never be lost.
  assign imem_read_out = reset_n & ~hold_full_q & ~redirect_in;
  assign imem_addr_out = pc_q;
  assign flush_out     = redirect_in;
  assign accept        = imem_read_out & imem_ready_in;
  assign next_pc       = pred_taken ? pred_target : pc_q + INSTR_BYTES;

  always_comb begin
    resp       = BUBBLE;
    resp.valid = 1'b1;
    resp.pc    = pc_q;
    resp.instr = imem_data_in;
    resp.pred  = pred_taken;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q        <= RESET_VECTOR;
      hold_full_q <= 1'b0;
      hold_q      <= BUBBLE;
      out_q       <= BUBBLE;
    end else if (redirect_in) begin
      pc_q        <= redirect_pc_in;
      hold_full_q <= 1'b0;
      out_q       <= BUBBLE;
    end else if (!stall_in) begin
      if (hold_full_q) begin
        out_q       <= hold_q;
        hold_full_q <= 1'b0;
      end else if (accept) begin
        out_q <= resp;
        pc_q  <= next_pc;
      end else begin
        out_q <= BUBBLE;
      end
    end else if (accept) begin
      hold_q      <= resp;
      hold_full_q <= 1'b1;
      pc_q        <= next_pc;
    end
  end

  assign valid_out                  = out_q.valid;
  assign pc_out                     = out_q.pc;
  assign instr_out                  = out_q.instr;
  assign branch_predicted_taken_out = out_q.pred;

  logic unused_hit;
  assign unused_hit = pred_hit;

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed scenarios then randomized traffic vs. a reference model.
module tb_fetch;
  localparam logic [63:0] RV = 64'h1000;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall_in, redirect_in, bp_update_in, bp_taken_in, imem_ready_in;
  logic [63:0] redirect_pc_in, bp_pc_in, bp_target_in, imem_data_in;
  logic [63:0] imem_addr_out, pc_out, instr_out;
  logic        imem_read_out, flush_out, valid_out, branch_predicted_taken_out;

  int checks = 0;
  int failures = 0;

  fetch #(.RESET_VECTOR(RV), .BTB_ENTRIES(N)) dut (
    .clk(clk), .reset_n(reset_n), .stall_in(stall_in), .redirect_in(redirect_in),
    .redirect_pc_in(redirect_pc_in), .bp_update_in(bp_update_in), .bp_pc_in(bp_pc_in),
    .bp_taken_in(bp_taken_in), .bp_target_in(bp_target_in), .imem_addr_out(imem_addr_out),
    .imem_read_out(imem_read_out), .imem_ready_in(imem_ready_in), .imem_data_in(imem_data_in),
    .flush_out(flush_out), .valid_out(valid_out), .pc_out(pc_out), .instr_out(instr_out),
    .branch_predicted_taken_out(branch_predicted_taken_out)
  );

  always #5 clk = ~clk;

  // Reference model state: architectural view of PC, parked response, output slot, BTB.
  logic [63:0] m_pc;
  bit          m_hf;
  logic [63:0] m_hpc, m_hins;
  bit          m_hpred;
  bit          m_v, m_opred;
  logic [63:0] m_opc, m_oins;
  bit          b_v[N];
  logic [63:0] b_pc[N];
  logic [63:0] b_tgt[N];
  int          b_ct[N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [63:0] pc);
    return int'((pc >> 3) % N);
  endfunction

  // Prediction: matching entry (same pc above the 3 byte bits) with counter 2 or 3.
  task automatic predict(input logic [63:0] pc, output bit tk, output logic [63:0] tgt);
    int i;
    i = idx_of(pc);
    tk  = b_v[i] && ((b_pc[i] >> 3) / N == (pc >> 3) / N) && (b_ct[i] >= 2);
    tgt = tk ? b_tgt[i] : pc + 64'd8;
  endtask

  task automatic model_reset();
    m_pc = RV; m_hf = 0; m_v = 0; m_opc = 0; m_oins = 0; m_opred = 0;
    for (int i = 0; i < N; i++) b_v[i] = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, {63'h0, valid_out}, {63'h0, m_v});
    chk({tag, ".pc"},    pc_out, m_opc);
    chk({tag, ".instr"}, instr_out, m_oins);
    chk({tag, ".pred"},  {63'h0, branch_predicted_taken_out}, {63'h0, m_opred});
  endtask

  // One clock: inputs already driven at the negedge; returns at the next negedge.
  task automatic step(input string tag);
    bit rd, acc, tk, hit;
    logic [63:0] nxt;
    int i;
    #1;
    rd = reset_n && !m_hf && !redirect_in;
    chk({tag, ".read"},  {63'h0, imem_read_out}, {63'h0, rd});
    chk({tag, ".addr"},  imem_addr_out, m_pc);
    chk({tag, ".flush"}, {63'h0, flush_out}, {63'h0, redirect_in});
    predict(m_pc, tk, nxt);
    acc = rd && imem_ready_in;
    @(posedge clk);
    if (!reset_n) model_reset();
    else begin
      if (redirect_in) begin
        m_pc = redirect_pc_in; m_hf = 0; m_v = 0; m_opc = 0; m_oins = 0; m_opred = 0;
      end else if (!stall_in) begin
        if (m_hf) begin
          m_v = 1; m_opc = m_hpc; m_oins = m_hins; m_opred = m_hpred; m_hf = 0;
        end else if (acc) begin
          m_v = 1; m_opc = m_pc; m_oins = imem_data_in; m_opred = tk; m_pc = nxt;
        end else begin
          m_v = 0; m_opc = 0; m_oins = 0; m_opred = 0;
        end
      end else if (acc) begin
        m_hf = 1; m_hpc = m_pc; m_hins = imem_data_in; m_hpred = tk; m_pc = nxt;
      end
      if (bp_update_in) begin
        i = idx_of(bp_pc_in);
        hit = b_v[i] && ((b_pc[i] >> 3) / N == (bp_pc_in >> 3) / N);
        if (bp_taken_in) begin
          if (hit) begin
            b_ct[i] = (b_ct[i] == 3) ? 3 : b_ct[i] + 1; b_tgt[i] = bp_target_in;
          end else begin
            b_v[i] = 1; b_pc[i] = bp_pc_in; b_tgt[i] = bp_target_in; b_ct[i] = 2;
          end
        end else if (hit) begin
          b_ct[i] = (b_ct[i] == 0) ? 0 : b_ct[i] - 1;
        end
      end
    end
    #1;
    check_outputs(tag);
    @(negedge clk);
    imem_data_in = {$urandom, $urandom};
  endtask

  task automatic idle_inputs();
    stall_in = 0; redirect_in = 0; redirect_pc_in = 0; bp_update_in = 0;
    bp_pc_in = 0; bp_taken_in = 0; bp_target_in = 0; imem_ready_in = 0;
  endtask

  // Asynchronous reset assertion: outputs must return to reset values without a clock.
  task automatic pulse_reset(input string tag);
    reset_n = 0;
    #1;
    model_reset();
    check_outputs(tag);
    chk({tag, ".read"}, {63'h0, imem_read_out}, 64'h0);
    chk({tag, ".addr"}, imem_addr_out, RV);
    step({tag, ".held"});
    reset_n = 1;
  endtask

  initial begin
    idle_inputs();
    imem_data_in = 64'hDEAD_BEEF_0000_0001;
    reset_n = 1;
    model_reset();
    @(negedge clk);

    // Reset, then streaming with ready held high.
    pulse_reset("rst");
    imem_ready_in = 1;
    step("s0"); chk("s0.pc_out", pc_out, 64'h1000); chk("s0.valid", {63'h0, valid_out}, 64'h1);
    step("s1"); chk("s1.pc_out", pc_out, 64'h1008);
    step("s2"); chk("s2.pc_out", pc_out, 64'h1010);

    // Response during stall parks in the hold buffer; released one cycle after stall falls.
    pulse_reset("rst2");
    imem_ready_in = 1; stall_in = 1;
    step("h0"); chk("h0.valid", {63'h0, valid_out}, 64'h0);
    step("h1"); chk("h1.read_dropped", {63'h0, imem_read_out}, 64'h0);
    stall_in = 0;
    step("h2"); chk("h2.pc_out", pc_out, 64'h1000);
    step("h3"); chk("h3.pc_out", pc_out, 64'h1008);

    // Redirect with stall and a pending response, hold buffer full.
    stall_in = 1;
    step("r0");
    redirect_in = 1; redirect_pc_in = 64'h2000;
    step("r1"); chk("r1.bubble", {63'h0, valid_out}, 64'h0);
    redirect_in = 0; stall_in = 0;
    #1; chk("r2.addr", imem_addr_out, 64'h2000); chk("r2.read", {63'h0, imem_read_out}, 64'h1);
    step("r2"); chk("r2.pc_out", pc_out, 64'h2000);

    // Train 0x1010 -> 0x3000 taken twice, then fetch it.
    imem_ready_in = 0; bp_update_in = 1; bp_pc_in = 64'h1010; bp_taken_in = 1; bp_target_in = 64'h3000;
    step("t0"); step("t1");
    bp_update_in = 0; redirect_in = 1; redirect_pc_in = 64'h1010;
    step("t2");
    redirect_in = 0; imem_ready_in = 1;
    step("t3"); chk("t3.pred", {63'h0, branch_predicted_taken_out}, 64'h1);
    chk("t3.next", imem_addr_out, 64'h3000);
    imem_ready_in = 0; bp_update_in = 1; bp_taken_in = 0;
    step("t4"); step("t5");
    bp_update_in = 0; redirect_in = 1;
    step("t6");
    redirect_in = 0; imem_ready_in = 1;
    step("t7"); chk("t7.pred", {63'h0, branch_predicted_taken_out}, 64'h0);
    chk("t7.next", imem_addr_out, 64'h1018);

    // Same-cycle allocate and lookup: old contents seen, new entry used afterwards.
    redirect_in = 1; redirect_pc_in = 64'h4000;
    step("u0");
    redirect_in = 0; bp_update_in = 1; bp_pc_in = 64'h4000; bp_taken_in = 1; bp_target_in = 64'h5000;
    step("u1"); chk("u1.pred", {63'h0, branch_predicted_taken_out}, 64'h0);
    chk("u1.next", imem_addr_out, 64'h4008);
    bp_update_in = 0; redirect_in = 1;
    step("u2");
    redirect_in = 0;
    step("u3"); chk("u3.pred", {63'h0, branch_predicted_taken_out}, 64'h1);
    chk("u3.next", imem_addr_out, 64'h5000);

    // PC increment wraps at the top of the address space.
    redirect_in = 1; redirect_pc_in = 64'hFFFF_FFFF_FFFF_FFF8;
    step("w0");
    redirect_in = 0;
    step("w1"); chk("w1.wrap", imem_addr_out, 64'h0);

    // Ready withheld: bubbles with a stable address, then a mid-stream reset.
    imem_ready_in = 0;
    for (int k = 0; k < 3; k++) begin
      step("nr"); chk("nr.valid", {63'h0, valid_out}, 64'h0); chk("nr.instr", instr_out, 64'h0);
      chk("nr.addr", imem_addr_out, 64'h0);
    end
    imem_ready_in = 1;
    step("m0");
    pulse_reset("rst3");
    step("m1"); chk("m1.refetch", pc_out, RV);

    // Randomized traffic; small PC range so BTB indices alias and tags conflict.
    for (int k = 0; k < 600; k++) begin
      stall_in       = ($urandom % 4) == 0;
      imem_ready_in  = ($urandom % 3) != 0;
      redirect_in    = ($urandom % 16) == 0;
      redirect_pc_in = 64'h1000 + 64'(8 * $urandom_range(0, 31));
      bp_update_in   = ($urandom % 3) == 0;
      bp_pc_in       = 64'h1000 + 64'(8 * $urandom_range(0, 31));
      bp_taken_in    = ($urandom % 3) != 0;
      bp_target_in   = 64'h1000 + 64'(8 * $urandom_range(0, 31));
      if (k == 300) pulse_reset("rnd_rst");
      else step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
